// File: rtl/data_ram.sv
// Single-port 32-bit word RAM with a req/ack handshake, byte-lane writes and error reporting.
// Define DATA_RAM_WAIT_EN to insert WAIT_CYCLES wait states before each response.
module data_ram #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      r_state;
  logic [31:0] r_rdata;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic          w_fire;
  logic          w_illegal;
  logic [AW-1:0] w_idx;
  logic          w_mem_we;

`ifdef DATA_RAM_WAIT_EN
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [3:0]  r_cnt;

  assign w_we    = r_we;
  assign w_addr  = r_addr;
  assign w_wdata = r_wdata;
  assign w_be    = r_be;
  assign w_fire  = (r_state == WAIT) && (r_cnt == '0);
`else
  // Without wait states the capture edge is also the edge entering RESP,
  // so the access uses the request fields as they are sampled on that edge.
  assign w_we    = we_i;
  assign w_addr  = addr_i;
  assign w_wdata = wdata_i;
  assign w_be    = be_i;
  assign w_fire  = (r_state == IDLE) && req_i;
`endif

  assign w_illegal = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= 32'(DEPTH));
  assign w_idx     = w_addr[AW+1:2];
  // Gated by rst so an edge seen while reset is held never commits a write.
  assign w_mem_we  = rst && w_fire && w_we && !w_illegal;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
`ifdef DATA_RAM_WAIT_EN
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
`endif
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (w_fire) begin
        r_ack <= 1'b1;
        r_err <= w_illegal;
        if (w_illegal) begin
          r_rdata <= '0;
        end else if (!w_we) begin
          r_rdata <= r_mem[w_idx];
        end
      end

      case (r_state)
        IDLE: begin
          if (req_i) begin
`ifdef DATA_RAM_WAIT_EN
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_be    <= be_i;
            r_cnt   <= 4'(WAIT_CYCLES - 1);
            r_state <= WAIT;
`else
            r_state <= RESP;
`endif
          end
        end
`ifdef DATA_RAM_WAIT_EN
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`endif
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rdata_o = r_rdata;
  assign ack_o   = r_ack;
  assign err_o   = r_err;

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: a word-array reference model predicts each response,
// a negedge monitor compares it whenever ack_o is presented.
module tb_data_ram;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAITC = 3;
`ifdef DATA_RAM_WAIT_EN
  localparam int unsigned LAT = WAITC + 1;
`else
  localparam int unsigned LAT = 1;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be    = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  data_ram #(
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .be_i   (be),
    .rdata_o(rdata),
    .ack_o  (ack),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [DEPTH];
  logic [31:0] model_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: apply one transaction and queue the response it must produce.
  task automatic model_issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] b);
    exp_t        e;
    logic [31:0] mask;
    int unsigned idx;
    idx = a >> 2;
    if (a[1:0] != 2'b00 || idx >= DEPTH) begin
      model_rd = '0;
      e.err    = 1'b1;
    end else begin
      e.err = 1'b0;
      if (w) begin
        mask = '0;
        for (int i = 0; i < 4; i++) if (b[i]) mask[8*i +: 8] = 8'hFF;
        model[idx] = (model[idx] & ~mask) | (wd & mask);
      end else begin
        model_rd = model[idx];
      end
    end
    e.rd = model_rd;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (ack) begin
      exp_t e;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack with empty queue, expected none");
      end else begin
        e = sbq.pop_front();
        chk("err_o", {31'b0, err}, {31'b0, e.err});
        chk("rdata_o", rdata, e.rd);
      end
    end
  end

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, output logic [31:0] got);
    int n;
    bit seen;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd; be = b;
    model_issue(w, a, wd, b);
    n = 0;
    seen = 0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      if (ack) begin
        seen = 1;
      end else begin
        // Captured fields must not follow later input changes.
        we    = 1'($urandom_range(0, 1));
        addr  = $urandom;
        wdata = $urandom;
        be    = 4'($urandom_range(0, 15));
      end
    end
    got = rdata;
    req = 1'b0;
    if (!seen) $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack", n);
    chk("latency", 32'(n), 32'(LAT));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [7:0]  pat;
    int          acks;

    model_rd = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'b0, ack}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rst = 1'b1;

    for (int unsigned i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), 32'd0, 4'hF, got);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
    txn(1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("full_word_read", got, 32'hDEADBEEF);

    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, got);
    txn(1'b0, 32'h10, 32'h0, 4'hF, got);
    chk("byte_lane_read", got, 32'hDEADBEAA);

    txn(1'b0, 32'h13, 32'h0, 4'hF, got);
    chk("misaligned_rdata", got, 32'd0);
    txn(1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, got);
    chk("out_of_range_rdata", got, 32'd0);
    txn(1'b1, 32'h11, 32'h55555555, 4'hF, got);
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, got);
    txn(1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("unchanged_after_illegal_and_be0", got, 32'hDEADBEAA);
    txn(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, got);
    chk("rdata_held_over_write", got, 32'hDEADBEAA);

    txn(1'b1, 32'h0, 32'h11111111, 4'hF, got);
    txn(1'b1, 32'h4, 32'h22222222, 4'hF, got);
    txn(1'b1, 32'h8, 32'h33333333, 4'hF, got);
    @(negedge clk);
    model_issue(1'b0, 32'h0, 32'h0, 4'h0);
    model_issue(1'b0, 32'h4, 32'h0, 4'h0);
    model_issue(1'b0, 32'h8, 32'h0, 4'h0);
    req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'($urandom_range(0, 15));
    pat  = '0;
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 8) pat[k] = ack;
      if (ack) begin
        acks++;
        if (acks == 3) req = 1'b0;
        else addr = 32'(acks * 4);
      end
    end
    chk("b2b_ack_count", 32'(acks), 32'd3);
`ifndef DATA_RAM_WAIT_EN
    chk("b2b_ack_pattern", {24'b0, pat}, 32'h15);
`endif

`ifdef DATA_RAM_WAIT_EN
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_ack", {31'b0, ack}, 32'd0);
    chk("abort_err", {31'b0, err}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    model_rd = '0;
    @(negedge clk);
    rst = 1'b1;
    txn(1'b0, 32'h20, 32'h0, 4'h0, got);
    chk("aborted_write_absent", got, 32'h0);
`else
    @(negedge clk);
    model_issue(1'b0, 32'h10, 32'h0, 4'h0);
    req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'h0;
    @(negedge clk);
    req = 1'b0;
    chk("resp_ack_before_reset", {31'b0, ack}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_ack", {31'b0, ack}, 32'd0);
    chk("async_reset_err", {31'b0, err}, 32'd0);
    chk("async_reset_rdata", rdata, 32'd0);
    model_rd = '0;
    @(negedge clk);
    rst = 1'b1;
`endif
    txn(1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("memory_kept_over_reset", got, 32'hDEADBEAA);

    for (int t = 0; t < 300; t++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = $urandom | 32'(4 * DEPTH);
      else             a = 32'($urandom_range(0, DEPTH - 1) * 4);
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), got);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 The module SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the array (power of two).
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted when DATA_RAM_WAIT_EN is defined (legal range 1..15).
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port req_i, input, 1, the initiator's request, held high until ack_o is seen.
REQ-006 Port we_i, input, 1, 1 = write, 0 = read.
REQ-007 Port addr_i, input, 32, byte address.
REQ-008 Port wdata_i, input, 32, write data.
REQ-009 Port be_i, input, 4, byte-lane write enables; be_i[n] covers wdata_i[8n+7:8n].
REQ-010 Port rdata_o, output, 32, registered read data.
REQ-011 Port ack_o, output, 1, one-cycle completion pulse.
REQ-012 Port err_o, output, 1, error flag, valid only while ack_o=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with req_i=1, the block SHALL latch we_i, addr_i, wdata_i and be_i at the clock edge; later input changes SHALL NOT affect the transaction.
REQ-015 From the capture edge, the FSM SHALL go to WAIT if DATA_RAM_WAIT_EN is defined, otherwise directly to RESP.
REQ-016 WAIT SHALL count down a counter loaded with WAIT_CYCLES-1 and SHALL move to RESP on the edge where the counter is 0.
REQ-017 On the edge entering RESP, a legal write SHALL update only the enabled byte lanes of the word at addr[log2(DEPTH)+1:2].
REQ-018 On the same edge, a legal read SHALL load rdata_o with the full word, regardless of be_i.
REQ-019 ack_o SHALL be 1 for exactly the one cycle spent in RESP; RESP SHALL always go to IDLE.
REQ-020 Latency from capture edge to ack_o high SHALL be 1 cycle without the macro and WAIT_CYCLES+1 cycles with it.
REQ-021 In RESP, req_i SHALL be ignored.
REQ-022 If req_i is still high in the following IDLE cycle, it SHALL start a new transaction, giving back-to-back throughput of one transaction per 2 cycles without the macro.
REQ-023 An illegal request (addr_i[1:0]!=0 or word index >= DEPTH) SHALL complete with ack_o=1, err_o=1 and rdata_o=0, with no write.
REQ-024 A write with be_i=4'b0000 SHALL be acknowledged with err_o=0 and leave memory unchanged.
REQ-025 rdata_o SHALL hold its last value after a read until the next read completes; writes SHALL NOT change it.
REQ-026 A read to the address written by the immediately preceding transaction SHALL return the new data.

Reset
REQ-027 rst=0 SHALL asynchronously force state=IDLE, counter=0, ack_o=0, err_o=0 and rdata_o=0.
REQ-028 Reset asserted in WAIT SHALL abort the transaction with no write committed; array contents SHALL NOT be cleared by reset.
REQ-029 The first capture after reset release SHALL occur no earlier than the first rising clk edge with rst=1.

Configuration
REQ-030 Macro DATA_RAM_WAIT_EN: when defined, the WAIT state and counter SHALL exist and latency SHALL be WAIT_CYCLES+1.
REQ-031 When DATA_RAM_WAIT_EN is undefined, WAIT and the counter SHALL be compiled out, latency SHALL be 1, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Write addr 0x10, data 0xDEADBEEF, be 4'hF, then read 0x10 -> ack_o pulse for each; read returns rdata_o=0xDEADBEEF, err_o=0.
REQ-033 With 0x10 holding 0xDEADBEEF, write 0x000000AA with be 4'b0001, then read 0x10 -> rdata_o=0xDEADBEAA.
REQ-034 Read addr 0x13, and separately read addr 4*DEPTH -> ack_o=1, err_o=1, rdata_o=0; memory unchanged.
REQ-035 With macro and WAIT_CYCLES=3, read request -> ack_o rises exactly 4 cycles after the capture edge; without macro -> exactly 1 cycle.
REQ-036 Drive rst=0 mid-WAIT on a write of 0x12345678 to 0x20 (prior content 0) -> outputs 0 immediately; a later read of 0x20 returns 0x00000000.
REQ-037 Hold req_i high for three reads of 0x0, 0x4, 0x8 -> three single-cycle ack_o pulses separated by one IDLE cycle each (no macro).
